serial_adder_ctrl: RTL

//  Sequencer that performs WIDTH-bit addition bit-serially through one instance of
//  the team's gate-level fulladder cell, one bit per clock, LSB first.
//  - Holds operand shift registers and a carry flip-flop around the adder.
//  - Runs a start/busy/done handshake for the surrounding datapath.
//  - Area-minimal alternative to a WIDTH-wide ripple adder.

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/fulladder.sv | 16 +
 rtl/serial_adder_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared state encoding and default width for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_add_state_t;

  localparam int SERIAL_ADD_W = 8;

endpackage

// File: rtl/fulladder.sv
// Gate-level one-bit full adder cell used as the bit-slice of the serial adder.
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic halfSum;

  assign halfSum = a_i ^ b_i;
  assign s_o     = halfSum ^ c_i;
  assign c_o     = (a_i & b_i) | (c_i & halfSum);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one fulladder slice, LSB first, start/busy/done handshake.
// Build option SERIAL_SUB_EN adds a 'sub' input selecting a - b instead of a + b + c.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  serial_add_state_t state_q, state_d;
  logic [WIDTH-1:0]  aSh_q, aSh_d;
  logic [WIDTH-1:0]  bSh_q, bSh_d;
  logic [WIDTH-1:0]  sumSh_q, sumSh_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cOut_q, cOut_d;
  logic              subSel;
  logic              faSum;
  logic              faCarry;

`ifdef SERIAL_SUB_EN
  assign subSel = sub;
`else
  assign subSel = 1'b0;
`endif

  fulladder u_fa (
    .a_i (aSh_q[0]),
    .b_i (bSh_q[0]),
    .c_i (carry_q),
    .s_o (faSum),
    .c_o (faCarry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      sumSh_q <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      s_q     <= '0;
      cOut_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      sumSh_q <= sumSh_d;
      carry_q <= carry_d;
      count_q <= count_d;
      s_q     <= s_d;
      cOut_q  <= cOut_d;
    end
  end

  // Result registers load on the edge that enters DONE, so they take the final
  // sum bit directly from the slice rather than from the not-yet-updated shifter.
  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    sumSh_d = sumSh_q;
    carry_d = carry_q;
    count_d = count_q;
    s_d     = s_q;
    cOut_d  = cOut_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          aSh_d   = a;
          bSh_d   = subSel ? ~b : b;
          carry_d = subSel ? 1'b1 : c;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sumSh_d = {faSum, sumSh_q[WIDTH-1:1]};
        carry_d = faCarry;
        aSh_d   = aSh_q >> 1;
        bSh_d   = bSh_q >> 1;
        count_d = count_q + CNT_ONE;
        if (count_q == CNT_LAST) begin
          s_d     = sumSh_d;
          cOut_d  = faCarry;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy  = (state_q == RUN) || (state_q == DONE);
  assign done  = (state_q == DONE);
  assign s     = s_q;
  assign c_out = cOut_q;

endmodule
